bcd_share_ctrl: RTL and testbench

Sequential controller that shares one iterative binary-to-BCD converter between two requesters in the calculator: operand entry and ALU result. It arbitrates round-robin and latches the granted value. It runs one shift-add-3 (double-dabble) pass per clock and returns hundreds/tens/units digits plus a sign flag to the display path with a per-requester acknowledge.

---
 rtl/bcd_share_ctrl_pkg.sv | 20 ++
 rtl/bcd_share_ctrl_if.sv | 26 ++
 rtl/bcd_share_ctrl_iter_core.sv | 13 +
 rtl/bcd_share_ctrl.sv | 142 ++++++++++++++
 tb/tb_bcd_share_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/bcd_share_ctrl_pkg.sv
// Shared types and constants for the shared binary-to-BCD converter controller.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Hundreds in [11:8], tens in [7:4], units in [3:0].
    typedef logic [11:0] bcd3_t;

    localparam int         NUM_REQ     = 2;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= ADD3_THRESH) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_share_ctrl_if.sv
// Requester/display bundle between the two requesters and the shared BCD converter.
interface bcd_share_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [bcd_pkg::NUM_REQ-1:0] req;
    logic [WIDTH-1:0]            val0;
    logic [WIDTH-1:0]            val1;
    logic [bcd_pkg::NUM_REQ-1:0] ack;
    logic                        busy;
    logic                        out_valid;
    logic                        out_id;
    logic [3:0]                  centenas;
    logic [3:0]                  dezenas;
    logic [3:0]                  unidades;
    logic                        negativo;

    modport master (
        output req, val0, val1,
        input  ack, busy, out_valid, out_id, centenas, dezenas, unidades, negativo
    );

    modport slave (
        input  req, val0, val1,
        output ack, busy, out_valid, out_id, centenas, dezenas, unidades, negativo
    );
endinterface

// File: rtl/bcd_share_ctrl_iter_core.sv
// One double-dabble step: add-3 correction on every digit, then shift in one magnitude bit.
module bcd_iter_core
    import bcd_pkg::*;
(
    input  bcd3_t acc_in,
    input  logic  bit_in,
    output bcd3_t acc_out
);
    bcd3_t corr;

    assign corr    = {add3(acc_in[11:8]), add3(acc_in[7:4]), add3(acc_in[3:0])};
    assign acc_out = {corr[10:0], bit_in};
endmodule

// File: rtl/bcd_share_ctrl.sv
// Round-robin shared binary-to-BCD converter controller, one double-dabble step per clock.
// Define BCD_SHARE_SIGNED_EN for two's-complement inputs with a sign flag on negativo.
module bcd_share_ctrl
    import bcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    bcd_share_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                last_gnt;
    logic                gnt_q;
    logic                gnt_nxt;
    logic                start;
    logic [WIDTH-1:0]    sel_val;
    logic [WIDTH-1:0]    sel_mag;
    logic                sel_neg;
    logic [WIDTH-1:0]    mag_p0;
    logic                sign_p0;
    bcd3_t               acc_p0;
    bcd3_t               acc_nxt;
    logic [NUM_REQ-1:0]  ack_q;
    logic                busy_q;
    logic                valid_q;
    logic                id_q;
    logic                neg_q;
    logic [3:0]          cen_q;
    logic [3:0]          dez_q;
    logic [3:0]          uni_q;

    // A lone requester always wins; on contention the one not served last time wins.
    always_comb begin
        gnt_nxt = bus.req[1];
        if (&bus.req) gnt_nxt = ~last_gnt;
    end

    assign start   = (state == IDLE) && (|bus.req);
    assign sel_val = gnt_nxt ? bus.val1 : bus.val0;

`ifdef BCD_SHARE_SIGNED_EN
    // Most negative input wraps to itself, which reads correctly as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] to_mag(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] u;
        u = v;
        return u[WIDTH-1] ? (~u + WIDTH'(1)) : u;
    endfunction

    assign sel_neg = sel_val[WIDTH-1];
    assign sel_mag = to_mag(sel_val);
`else
    assign sel_neg = 1'b0;
    assign sel_mag = sel_val;
`endif

    // ---- stage p0: latched operand and BCD accumulator (data path, no reset) ----
    always_ff @(posedge clk) begin
        if (start) begin
            mag_p0  <= sel_mag;
            sign_p0 <= sel_neg;
            acc_p0  <= '0;
        end else if (state == SHIFT) begin
            acc_p0  <= acc_nxt;
        end
    end

    bcd_iter_core u_core (
        .acc_in  (acc_p0),
        .bit_in  (mag_p0[cnt]),
        .acc_out (acc_nxt)
    );

    // ---- control FSM and registered outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            last_gnt <= 1'b1;
            gnt_q    <= 1'b0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            id_q     <= 1'b0;
            neg_q    <= 1'b0;
            cen_q    <= '0;
            dez_q    <= '0;
            uni_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SHIFT;
                        gnt_q    <= gnt_nxt;
                        last_gnt <= gnt_nxt;
                        cnt      <= CW'(WIDTH - 1);
                        busy_q   <= 1'b1;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - 1'b1;
                    // Final step goes straight to the outputs so they are valid in DONE.
                    if (cnt == '0) begin
                        state   <= DONE;
                        valid_q <= 1'b1;
                        ack_q   <= gnt_q ? 2'b10 : 2'b01;
                        id_q    <= gnt_q;
                        cen_q   <= acc_nxt[11:8];
                        dez_q   <= acc_nxt[7:4];
                        uni_q   <= acc_nxt[3:0];
                        neg_q   <= sign_p0;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = valid_q;
    assign bus.out_id    = id_q;
    assign bus.centenas  = cen_q;
    assign bus.dezenas   = dez_q;
    assign bus.unidades  = uni_q;
    assign bus.negativo  = neg_q;

endmodule

// File: tb/tb_bcd_share_ctrl.sv
// Directed bench for bcd_share_ctrl; expectations follow BCD_SHARE_SIGNED_EN when defined.
module tb_bcd_share_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    bcd_share_ctrl_if #(.WIDTH(8)) bus ();

    bcd_share_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef BCD_SHARE_SIGNED_EN
    localparam logic [11:0] E80 = 12'h128;  localparam logic N80 = 1'b1;
    localparam logic [11:0] EFF = 12'h001;  localparam logic NFF = 1'b1;
    localparam logic [11:0] E9C = 12'h100;  localparam logic N9C = 1'b1;
`else
    localparam logic [11:0] E80 = 12'h128;  localparam logic N80 = 1'b0;
    localparam logic [11:0] EFF = 12'h255;  localparam logic NFF = 1'b0;
    localparam logic [11:0] E9C = 12'h156;  localparam logic N9C = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] digits();
        return {bus.centenas, bus.dezenas, bus.unidades};
    endfunction

    task automatic convert(input logic id, input logic [7:0] v, input logic [11:0] exp_d,
                           input logic exp_neg, input string tag);
        int lat;
        if (id) begin bus.val1 = v; bus.req = 2'b10; end
        else    begin bus.val0 = v; bus.req = 2'b01; end
        tick();
        bus.req = 2'b00;
        lat = 1;
        chk({tag, "_busy_c1"}, 16'(bus.busy), 16'd1);
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 16'(lat), 16'd9);
        chk({tag, "_ack"}, 16'(bus.ack), id ? 16'd2 : 16'd1);
        chk({tag, "_id"}, 16'(bus.out_id), 16'(id));
        chk({tag, "_digits"}, 16'(digits()), 16'(exp_d));
        chk({tag, "_neg"}, 16'(bus.negativo), 16'(exp_neg));
        tick();
        chk({tag, "_valid_pulse"}, 16'(bus.out_valid), 16'd0);
        chk({tag, "_ack_pulse"}, 16'(bus.ack), 16'd0);
        chk({tag, "_busy_low"}, 16'(bus.busy), 16'd0);
        chk({tag, "_hold"}, 16'(digits()), 16'(exp_d));
    endtask

    initial begin
        int n_ack;
        int n_busy_low;
        int first_ack;
        int second_ack;
        logic [3:0] ids;
        logic [11:0] ack_digits [4];

        bus.req  = 2'b00;
        bus.val0 = '0;
        bus.val1 = '0;

        // Reset state
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_ack", 16'(bus.ack), 16'd0);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_id", 16'(bus.out_id), 16'd0);
        chk("rst_digits", 16'(digits()), 16'd0);
        chk("rst_neg", 16'(bus.negativo), 16'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 16'(bus.busy), 16'd0);

        // Single conversions
        convert(1'b0, 8'h7F, 12'h127, 1'b0, "v7f");
        convert(1'b1, 8'h80, E80, N80, "v80");
        convert(1'b1, 8'hFF, EFF, NFF, "vff");
        convert(1'b0, 8'h00, 12'h000, 1'b0, "v00");
        convert(1'b0, 8'h9C, E9C, N9C, "v9c");
        convert(1'b1, 8'h0A, 12'h010, 1'b0, "v0a");

        // Both requesting from reset: alternating grants, 10-cycle spacing
        rst_n = 1'b0;
        bus.val0 = 8'h12;
        bus.val1 = 8'h34;
        bus.req  = 2'b11;
        tick();
        rst_n = 1'b1;
        n_ack = 0;
        n_busy_low = 0;
        ids = '0;
        first_ack = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (!bus.busy) n_busy_low++;
            if (bus.out_valid) begin
                if (n_ack < 4) begin
                    ids[n_ack] = bus.out_id;
                    ack_digits[n_ack] = digits();
                    chk($sformatf("rr_cycle%0d", n_ack), 16'(c), 16'(9 + 10 * n_ack));
                end
                n_ack++;
            end
        end
        bus.req = 2'b00;
        chk("rr_count", 16'(n_ack), 16'd4);
        chk("rr_ids", 16'(ids), 16'b1010);
        chk("rr_busy_low", 16'(n_busy_low), 16'd4);
        chk("rr_dig0", 16'(ack_digits[0]), 16'h018);
        chk("rr_dig1", 16'(ack_digits[1]), 16'h052);
        tick();
        tick();

        // Asynchronous abort at cycle 4
        bus.val0 = 8'h7F;
        bus.req  = 2'b01;
        tick();
        bus.req = 2'b00;
        tick();
        tick();
        tick();
        chk("abort_busy_before", 16'(bus.busy), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 16'(bus.busy), 16'd0);
        chk("abort_valid", 16'(bus.out_valid), 16'd0);
        chk("abort_ack", 16'(bus.ack), 16'd0);
        chk("abort_id", 16'(bus.out_id), 16'd0);
        chk("abort_digits", 16'(digits()), 16'd0);
        tick();
        rst_n = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.out_valid || (bus.ack != 2'b00)) n_ack++;
        end
        chk("abort_no_ack", 16'(n_ack), 16'd0);
        convert(1'b0, 8'h7F, 12'h127, 1'b0, "after_abort");

        // Request 1 arriving mid-conversion waits for IDLE
        bus.val0 = 8'h0A;
        bus.val1 = 8'h2D;
        bus.req  = 2'b01;
        first_ack = 0;
        second_ack = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 2) bus.req = 2'b10;
            if (bus.out_valid && first_ack == 0) begin
                first_ack = c;
                chk("late_first_id", 16'(bus.out_id), 16'd0);
                chk("late_first_dig", 16'(digits()), 16'h010);
            end else if (bus.out_valid && second_ack == 0) begin
                second_ack = c;
                bus.req = 2'b00;
                chk("late_second_ack", 16'(bus.ack), 16'd2);
                chk("late_second_dig", 16'(digits()), 16'h045);
            end
        end
        chk("late_first_cycle", 16'(first_ack), 16'd9);
        chk("late_second_cycle", 16'(second_ack), 16'd19);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
